// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit: iterative 32-bit integer divider (signed and unsigned) for the
// execute stage. One restoring-division step per clock through a `adder`
// instance in subtract mode. The fixed latency is 34 cycles from the start
// edge to the done cycle.
//
// Also contains `adder`, a combinational 32-bit Kogge-Stone parallel-prefix
// adder/subtractor (s=1 computes a - b, and cout=1 means no borrow).
//
// div_unit ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   operation request, sampled only while busy=0
//   op_signed  in   1 = two's-complement operands, sampled with start
//   dividend   in   [31:0] sampled with start
//   divisor    in   [31:0] sampled with start
//   busy       out  high from the accepting edge until done is asserted
//   done       out  one-cycle pulse, results valid from this cycle
//   quotient   out  [31:0] held until the next operation's FIX edge
//   remainder  out  [31:0] held until the next operation's FIX edge
//   dz         out  divide-by-zero flag, held like the results
// ---------------------------------------------------------------------------

module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] b_eff;
    logic [31:0] g_bit;
    logic [31:0] p_bit;
    logic [31:0] g_grp;
    logic [31:0] p_grp;
    logic [31:0] g_nxt;
    logic [31:0] p_nxt;
    logic [31:0] carry;

    always_comb begin
        // NOTE: every variable written here gets a value before any
        // conditional path reads it, so no latch can be inferred.
        b_eff = b ^ {32{s}};
        g_bit = a & b_eff;
        p_bit = a ^ b_eff;
        g_grp = g_bit;
        p_grp = p_bit;
        // The carry-in (s) is folded into bit 0's generate term, so the
        // prefix tree sees no separate carry input.
        g_grp[0] = g_bit[0] | (p_bit[0] & s);
        g_nxt = g_grp;
        p_nxt = p_grp;
        for (int k = 1; k < 32; k = k * 2) begin
            g_nxt = g_grp;
            p_nxt = p_grp;
            for (int i = k; i < 32; i++) begin
                g_nxt[i] = g_grp[i] | (p_grp[i] & g_grp[i-k]);
                p_nxt[i] = p_grp[i] & p_grp[i-k];
            end
            g_grp = g_nxt;
            p_grp = p_nxt;
        end
        carry = {g_grp[30:0], s};
        sum   = p_bit ^ carry;
        cout  = g_grp[31];
    end
endmodule

module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        dz
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands as latched on the accepting edge. The FIX special cases
    // compare against these original values.
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        op_sgn;

    logic [31:0] b_abs;
    logic [31:0] q_sr;
    // The restoring step always leaves the top bit of the 33-bit partial
    // remainder at zero: r < |divisor| < 2^32. Only the low 32 bits are
    // stored, and bit 32 reappears as r_sh[32] after the shift.
    logic [31:0] r;
    logic        neg_q;
    logic        neg_r;
    logic [4:0]  cnt;

    logic [32:0] r_sh;
    logic [31:0] diff;
    logic        no_borrow;
    logic        ok;
    logic [31:0] a_abs;
    logic [31:0] b_abs_nxt;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_PREP;
            S_PREP:  state_nxt = S_ITER;
            S_ITER:  if (cnt == 5'd31) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- iteration datapath ----------------
    assign r_sh = {r, q_sr[31]};

    adder u_sub (
        .a    (r_sh[31:0]),
        .b    (b_abs),
        .s    (1'b1),
        .sum  (diff),
        .cout (no_borrow)
    );

    // The subtraction fits when the shifted remainder overflowed 32 bits
    // or the 32-bit subtract produced no borrow.
    assign ok = r_sh[32] | no_borrow;

    assign a_abs     = (op_sgn && a_reg[31]) ? (~a_reg + 32'd1) : a_reg;
    assign b_abs_nxt = (op_sgn && b_reg[31]) ? (~b_reg + 32'd1) : b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only control and visible outputs are reset. Operand and
            // working registers are always loaded before use and need none.
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
            dz        <= 1'b0;
            cnt       <= 5'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg  <= dividend;
                        b_reg  <= divisor;
                        op_sgn <= op_signed;
                        busy   <= 1'b1;
                    end
                end
                S_PREP: begin
                    b_abs <= b_abs_nxt;
                    q_sr  <= a_abs;
                    r     <= 32'd0;
                    neg_q <= op_sgn & (a_reg[31] ^ b_reg[31]);
                    neg_r <= op_sgn & a_reg[31];
                    cnt   <= 5'd0;
                end
                S_ITER: begin
                    r    <= ok ? diff : r_sh[31:0];
                    q_sr <= {q_sr[30:0], ok};
                    cnt  <= cnt + 5'd1;
                end
                S_FIX: begin
                    if (b_reg == 32'd0) begin
                        quotient  <= 32'hFFFF_FFFF;
                        remainder <= a_reg;
                        dz        <= 1'b1;
                    end else if (op_sgn && a_reg == 32'h8000_0000 &&
                                 b_reg == 32'hFFFF_FFFF) begin
                        quotient  <= 32'h8000_0000;
                        remainder <= 32'd0;
                        dz        <= 1'b0;
                    end else begin
                        quotient  <= neg_q ? (~q_sr + 32'd1) : q_sr;
                        remainder <= neg_r ? (~r + 32'd1) : r;
                        dz        <= 1'b0;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit: self-checking bench for div_unit. It runs a table of directed
// vectors, randomized operations checked against an arithmetic reference,
// and hand-written sequences for ignored start, back-to-back start, and
// reset in the middle of an operation.
// ---------------------------------------------------------------------------

module tb_div_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic        op_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dz;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int LAT = 34;

    div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_signed (op_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: plain integer division semantics plus the two
    // special cases (divide by zero, signed overflow).
    function automatic void ref_div(input logic sgn, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] q,
                                    output logic [31:0] r,
                                    output logic dzo);
        int sa;
        int sb;
        sa  = a;
        sb  = b;
        dzo = 1'b0;
        if (b == 32'd0) begin
            q   = 32'hFFFF_FFFF;
            r   = a;
            dzo = 1'b1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issues one operation and waits (bounded) for done. If immediate=0, the
    // start is driven from the next negedge. Otherwise it is driven now, with
    // the caller sampling the done cycle. At cycle inj_at a foreign start is
    // pulsed, which must be ignored. lat counts edges from the start edge to
    // the sample where done is seen. busy_ok records that busy stayed high
    // until done and dropped with it.
    task automatic do_op(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input bit immediate,
                         input int inj_at, output int lat,
                         output bit busy_ok);
        if (!immediate) @(negedge clk);
        start     = 1'b1;
        op_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start   = 1'b0;
        lat     = 0;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && lat < 100) begin
            if (lat == inj_at) begin
                start     = 1'b1;
                op_signed = ~sgn;
                dividend  = 32'd1000;
                divisor   = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        if (busy !== 1'b0) busy_ok = 1'b0;
    endtask

    vec_t        vecs[11];
    int          lat;
    bit          bok;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          extra_done;

    initial begin
        vecs[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0};
        vecs[3]  = '{1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
        vecs[4]  = '{1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0};
        vecs[7]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1,         1'b0};
        vecs[8]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
        vecs[9]  = '{1'b1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1};
        vecs[10] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};

        rst       = 1'b1;
        start     = 1'b0;
        op_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset dz", {31'd0, dz}, 32'd0);

        // Directed table
        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0, -1, lat, bok);
            check($sformatf("vec%0d latency", i), lat, LAT);
            check($sformatf("vec%0d busy", i), {31'd0, bok}, 32'd1);
            check($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
            check($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
            check($sformatf("vec%0d dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d hold q", i), quotient, vecs[i].q);
        end

        // Ignored start mid-operation, then start in the done cycle
        do_op(1'b0, 32'd100, 32'd7, 1'b0, 10, lat, bok);
        check("inj latency", lat, LAT);
        check("inj quotient", quotient, 32'd14);
        check("inj remainder", remainder, 32'd2);
        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, -1, lat, bok);
        check("b2b latency", lat, LAT);
        check("b2b busy", {31'd0, bok}, 32'd1);
        check("b2b quotient", quotient, 32'hFFFF_FFF2);
        check("b2b remainder", remainder, 32'hFFFF_FFFE);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        check("no queued op", extra_done, 0);

        // Reset during ITER
        @(negedge clk);
        start     = 1'b1;
        op_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        check("midrst quotient", quotient, 32'd0);
        check("midrst remainder", remainder, 32'd0);
        check("midrst dz", {31'd0, dz}, 32'd0);
        do_op(1'b0, 32'd100, 32'd7, 1'b0, -1, lat, bok);
        check("postrst latency", lat, LAT);
        check("postrst quotient", quotient, 32'd14);
        check("postrst remainder", remainder, 32'd2);

        // rst and start in the same cycle: start is dropped
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        check("rst+start busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst+start idle", {31'd0, busy}, 32'd0);

        // Randomized against the reference model
        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [31:0] a;
            logic [31:0] b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'($urandom_range(1, 15));
                1:       b = -32'($urandom_range(1, 15));
                2:       b = (i % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            ref_div(s, a, b, eq, er, edz);
            do_op(s, a, b, 1'b0, -1, lat, bok);
            check($sformatf("rnd%0d latency", i), lat, LAT);
            check($sformatf("rnd%0d q (s=%0d a=%08h b=%08h)", i, s, a, b),
                  quotient, eq);
            check($sformatf("rnd%0d r (s=%0d a=%08h b=%08h)", i, s, a, b),
                  remainder, er);
            check($sformatf("rnd%0d dz", i), {31'd0, dz}, {31'd0, edz});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
